// File: rtl/l2_cache_control.sv
// l2_cache_control: direct-mapped L2 controller, 16 sets x one WIDTH-bit line.
// Tracks tag/valid/dirty and drives the external data array and physical memory.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mem_read/mem_write/mem_address  upstream request (held until mem_resp)
//   mem_wdata, mem_rdata, mem_resp  upstream line data and completion pulse
//   pmem_read/pmem_write            physical memory line read / writeback
//   pmem_address, pmem_wdata        line-aligned address, writeback line
//   pmem_rdata, pmem_resp           fill line, memory completion
//   arr_write/arr_index             data array write enable and set index
//   arr_datain, arr_dataout         data array write / combinational read data
//   hit_count/miss_count/writeback_count  (only with L2_PERF_CNT_EN defined)
//
// Optional feature macro: L2_PERF_CNT_EN (saturating performance counters).
module l2_cache_control #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [WIDTH-1:0]  mem_wdata,
    output logic [WIDTH-1:0]  mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [WIDTH-1:0]  pmem_wdata,
    input  logic [WIDTH-1:0]  pmem_rdata,
    input  logic              pmem_resp,
    output logic              arr_write,
    output logic [3:0]        arr_index,
    output logic [WIDTH-1:0]  arr_datain,
    input  logic [WIDTH-1:0]  arr_dataout
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       writeback_count
`endif
);

    localparam int TAG_W = ADDR_W - 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t           r_state;
    logic [TAG_W-1:0] r_tag [16];
    logic [15:0]      r_valid;
    logic [15:0]      r_dirty;

    logic [3:0]       w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_req;
    logic             w_hit;
    logic             w_fill;
    logic             w_unused;

    assign w_idx    = mem_address[8:5];
    assign w_tag    = mem_address[ADDR_W-1:9];
    assign w_req    = mem_read | mem_write;
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill   = (r_state == S_ALLOCATE) && pmem_resp;
    // Byte offset is irrelevant to a full-line cache.
    assign w_unused = ^mem_address[4:0];

    assign mem_rdata  = arr_dataout;
    assign pmem_wdata = arr_dataout;
    assign arr_index  = w_idx;

    always_comb begin
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        arr_write    = 1'b0;
        arr_datain   = '0;
        unique case (r_state)
            S_COMPARE: begin
                if (w_req && w_hit) begin
                    mem_resp = 1'b1;
                    // A simultaneous read+write is treated as a write.
                    if (mem_write) begin
                        arr_write  = 1'b1;
                        arr_datain = mem_wdata;
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_idx], w_idx, 5'b0};
            end
            S_ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_idx, 5'b0};
                if (pmem_resp) begin
                    arr_write  = 1'b1;
                    arr_datain = pmem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) r_state <= S_COMPARE;
                end
                S_COMPARE: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (w_hit) begin
                        r_state <= S_IDLE;
                        if (mem_write) r_dirty[w_idx] <= 1'b1;
                    end else if (r_dirty[w_idx]) begin
                        r_state <= S_WRITEBACK;
                    end else begin
                        r_state <= S_ALLOCATE;
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) r_state <= S_ALLOCATE;
                end
                S_ALLOCATE: begin
                    if (pmem_resp) begin
                        r_state        <= S_COMPARE;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_fill) r_tag[w_idx] <= w_tag;
    end

`ifdef L2_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic [31:0] r_wb_cnt;
    logic        w_cmp;

    assign w_cmp           = (r_state == S_COMPARE) && w_req;
    assign hit_count       = r_hit_cnt;
    assign miss_count      = r_miss_cnt;
    assign writeback_count = r_wb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (w_cmp && w_hit && (r_hit_cnt != '1))
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_cmp && !w_hit && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + 32'd1;
            // Writeback entry is exactly a dirty miss in COMPARE.
            if (w_cmp && !w_hit && r_dirty[w_idx] && (r_wb_cnt != '1))
                r_wb_cnt <= r_wb_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// tb_l2_cache_control: directed test of l2_cache_control with a behavioural
// data array and a fixed 3-cycle physical memory responder.
module tb_l2_cache_control;

    localparam int W  = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [W-1:0]  mem_wdata, mem_rdata;
    logic          mem_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [W-1:0]  pmem_wdata, pmem_rdata;
    logic          pmem_resp;
    logic          arr_write;
    logic [3:0]    arr_index;
    logic [W-1:0]  arr_datain, arr_dataout;
`ifdef L2_PERF_CNT_EN
    logic [31:0]   hit_count, miss_count, writeback_count;
`endif

    logic [W-1:0]  arr_mem [16];

    int checks = 0;
    int errors = 0;

    int            lat, nrd, nwr;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  wr_data, rdata;
    logic          aw, wb_first, both, done;

    l2_cache_control #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .arr_write    (arr_write),
        .arr_index    (arr_index),
        .arr_datain   (arr_datain),
        .arr_dataout  (arr_dataout)
`ifdef L2_PERF_CNT_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count),
        .writeback_count (writeback_count)
`endif
    );

    always #5 clk = ~clk;

    assign arr_dataout = arr_mem[arr_index];

    always @(posedge clk) begin
        if (arr_write) arr_mem[arr_index] <= arr_datain;
    end

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One upstream request; pmem answers 3 cycles after it is asserted.
    // rst_at > 0 pulls rst_n low in that cycle instead of waiting.
    task automatic xact(input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [W-1:0] wd,
                        input logic [W-1:0] fill, input int rst_at);
        int pw;
        lat = 0; nrd = 0; nwr = 0; aw = 0;
        wb_first = 0; both = 0; done = 0; pw = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; rdata = '0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr;
        mem_address = a; mem_wdata = wd;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (pmem_read | pmem_write) begin
                pw++;
                if (pw == 3) begin
                    pw = 0;
                    pmem_resp = 1'b1;
                    pmem_rdata = fill;
                    if (pmem_write) begin
                        nwr++;
                        wr_addr = pmem_address;
                        wr_data = pmem_wdata;
                        if (nrd == 0) wb_first = 1'b1;
                    end else begin
                        nrd++;
                        rd_addr = pmem_address;
                    end
                end
            end
            if (rst_at == c) begin
                rst_n = 1'b0;
                #1;
                chk("rst_pmem_read", W'(pmem_read), W'(0));
                chk("rst_mem_resp", W'(mem_resp), W'(0));
                done = 1'b1;
            end else begin
                #1;
                if (pmem_read && pmem_write) both = 1'b1;
                if (mem_resp) begin
                    lat = c + 1;
                    rdata = mem_rdata;
                    aw = arr_write;
                    done = 1'b1;
                end
            end
        end
        chk("completed", W'(done), W'(1));
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("single_resp", W'(mem_resp), W'(0));
        chk("pmem_exclusive", W'(both), W'(0));
    endtask

    logic [W-1:0] la, lb, lc, ld, le;

    initial begin
        la = {8{32'hA5A5_0001}};
        lb = {8{32'hB0B0_0002}};
        lc = {8{32'hC3C3_0003}};
        ld = {8{32'hD4D4_0004}};
        le = {8{32'hE5E5_0005}};
        for (int i = 0; i < 16; i++) arr_mem[i] = '0;
        mem_read = 0; mem_write = 0; mem_address = '0;
        mem_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
        rst_n = 1'b0;
        #22;
        chk("reset_mem_resp", W'(mem_resp), W'(0));
        chk("reset_pmem_read", W'(pmem_read), W'(0));
        chk("reset_pmem_write", W'(pmem_write), W'(0));
        chk("reset_arr_write", W'(arr_write), W'(0));
`ifdef L2_PERF_CNT_EN
        chk("reset_hit_cnt", W'(hit_count), W'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Cold read miss, clean allocate.
        xact(1, 0, 32'h0000_0040, '0, la, 0);
        chk("t1_lat", W'(lat), W'(6));
        chk("t1_nrd", W'(nrd), W'(1));
        chk("t1_rd_addr", W'(rd_addr), W'(32'h0000_0040));
        chk("t1_nwr", W'(nwr), W'(0));
        chk("t1_rdata", rdata, la);

        // Read hit.
        xact(1, 0, 32'h0000_0040, '0, '0, 0);
        chk("t2_lat", W'(lat), W'(2));
        chk("t2_npmem", W'(nrd + nwr), W'(0));
        chk("t2_rdata", rdata, la);

        // Write hit.
        xact(0, 1, 32'h0000_0040, lb, '0, 0);
        chk("t3_lat", W'(lat), W'(2));
        chk("t3_arr_write", W'(aw), W'(1));
        chk("t3_npmem", W'(nrd + nwr), W'(0));
        chk("t3_arr", arr_mem[2], lb);
`ifdef L2_PERF_CNT_EN
        chk("t3_hit_cnt", W'(hit_count), W'(3));
        chk("t3_miss_cnt", W'(miss_count), W'(1));
`endif

        // Dirty conflict miss: writeback B, then fill C.
        xact(1, 0, 32'h0000_0240, '0, lc, 0);
        chk("t4_nwr", W'(nwr), W'(1));
        chk("t4_wr_addr", W'(wr_addr), W'(32'h0000_0040));
        chk("t4_wr_data", wr_data, lb);
        chk("t4_wb_first", W'(wb_first), W'(1));
        chk("t4_nrd", W'(nrd), W'(1));
        chk("t4_rd_addr", W'(rd_addr), W'(32'h0000_0240));
        chk("t4_lat", W'(lat), W'(9));
        chk("t4_rdata", rdata, lc);
`ifdef L2_PERF_CNT_EN
        chk("t4_hit_cnt", W'(hit_count), W'(4));
        chk("t4_miss_cnt", W'(miss_count), W'(2));
        chk("t4_wb_cnt", W'(writeback_count), W'(1));
`endif

        // Read and write together on a hit: acts as a write.
        xact(1, 1, 32'h0000_0240, ld, '0, 0);
        chk("t5_lat", W'(lat), W'(2));
        chk("t5_arr_write", W'(aw), W'(1));
        chk("t5_arr", arr_mem[2], ld);

        // Line is now dirty: conflict writes back D to 0x240.
        xact(1, 0, 32'h0000_0040, '0, le, 0);
        chk("t6_nwr", W'(nwr), W'(1));
        chk("t6_wr_addr", W'(wr_addr), W'(32'h0000_0240));
        chk("t6_wr_data", wr_data, ld);
        chk("t6_lat", W'(lat), W'(9));
        chk("t6_rdata", rdata, le);

        // Reset while allocating idx 4.
        xact(1, 0, 32'h0000_0480, '0, la, 3);
        chk("t7_nrd", W'(nrd), W'(0));

        // Valid bits were cleared: 0x40 misses clean.
        xact(1, 0, 32'h0000_0040, '0, lb, 0);
        chk("t8_nrd", W'(nrd), W'(1));
        chk("t8_nwr", W'(nwr), W'(0));
        chk("t8_lat", W'(lat), W'(6));
        chk("t8_rdata", rdata, lb);

        // Abandoned address also misses after reset.
        xact(1, 0, 32'h0000_0480, '0, lc, 0);
        chk("t9_nrd", W'(nrd), W'(1));
        chk("t9_rd_addr", W'(rd_addr), W'(32'h0000_0480));
        chk("t9_rdata", rdata, lc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
